// File: rtl/ws2812_driver.sv
// rtl/ws2812_driver.sv - WS2812 single-wire serialiser for one GRB colour triple
module ws2812_driver #(
    parameter int BIT_CYCLES   = 12,
    parameter int T0H_CYCLES   = 4,
    parameter int T1H_CYCLES   = 8,
    parameter int RESET_CYCLES = 600,
    parameter int NUM_LEDS     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    input  logic       valid,
    output logic       ready,
    output logic       dout,
    output logic       frame_done
);
    localparam int CNT_MAX = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES : RESET_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int LW      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    localparam logic [CW-1:0] HI0_LAST   = CW'(T0H_CYCLES - 1);
    localparam logic [CW-1:0] HI1_LAST   = CW'(T1H_CYCLES - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [LW-1:0] LED_LAST   = LW'(NUM_LEDS - 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [4:0]    bit_cnt;
    logic [LW-1:0] led_cnt;
    logic [23:0]   shreg;
    logic [23:0]   hold;

    // cnt runs across a whole bit (HIGH then LOW) so each bit is exactly BIT_CYCLES long
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            led_cnt    <= '0;
            shreg      <= '0;
            hold       <= '0;
            ready      <= 1'b1;
            dout       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            dout       <= (state == HIGH);
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        shreg   <= {green, red, blue};
                        hold    <= {green, red, blue};
                        cnt     <= '0;
                        bit_cnt <= '0;
                        led_cnt <= '0;
                        ready   <= 1'b0;
                        state   <= HIGH;
                    end
                end
                HIGH: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == (shreg[23] ? HI1_LAST : HI0_LAST))
                        state <= LOW;
                end
                LOW: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (bit_cnt != 5'd23) begin
                            shreg   <= {shreg[22:0], 1'b0};
                            bit_cnt <= bit_cnt + 5'd1;
                            state   <= HIGH;
                        end else if (led_cnt != LED_LAST) begin
                            shreg   <= hold;
                            bit_cnt <= '0;
                            led_cnt <= led_cnt + LW'(1);
                            state   <= HIGH;
                        end else begin
                            frame_done <= (RESET_CYCLES == 1);
                            state      <= LATCH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LATCH: begin
                    if (cnt == LATCH_LAST) begin
                        ready <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt        <= cnt + 1'b1;
                        frame_done <= ((cnt + CW'(1)) == LATCH_LAST);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ws2812_driver.sv
// tb/tb_ws2812_driver.sv - scoreboard bench decoding dout against queued colour words
module tb_ws2812_driver;
    localparam int BIT = 6;
    localparam int T0H = 2;
    localparam int T1H = 4;
    localparam int RST = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] red = '0, green = '0, blue = '0;
    logic       valid_w [2];
    logic       ready_w [2];
    logic       dout_w  [2];
    logic       fd_w    [2];

    ws2812_driver #(.BIT_CYCLES(BIT), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H),
                    .RESET_CYCLES(RST), .NUM_LEDS(1)) dut1 (
        .clk(clk), .reset(reset), .red(red), .green(green), .blue(blue),
        .valid(valid_w[0]), .ready(ready_w[0]), .dout(dout_w[0]), .frame_done(fd_w[0]));

    ws2812_driver #(.BIT_CYCLES(BIT), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H),
                    .RESET_CYCLES(RST), .NUM_LEDS(3)) dut3 (
        .clk(clk), .reset(reset), .red(red), .green(green), .blue(blue),
        .valid(valid_w[1]), .ready(ready_w[1]), .dout(dout_w[1]), .frame_done(fd_w[1]));

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] w;
        int          acc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int          hi_len [2];
    int          lo_len [2];
    int          prev_hi[2];
    int          nbits  [2];
    int          last_fd[2];
    logic [71:0] acc    [2];
    logic        prev_d [2];
    logic        fd_prev[2];

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Accepting edge: the word on the inputs right now is what the frame must carry
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset && valid_w[0] && ready_w[0]) q0.push_back('{{green, red, blue}, cyc + 1});
        if (reset && valid_w[1] && ready_w[1]) q1.push_back('{{green, red, blue}, cyc + 1});
    end

    task automatic mon_step(input int d, input logic dv, input logic fdv, input logic rdy);
        int   nl;
        int   qsz;
        exp_t e;
        nl  = (d == 0) ? 1 : 3;
        qsz = (d == 0) ? q0.size() : q1.size();
        if (!reset) begin
            hi_len[d] = 0; lo_len[d] = 0; prev_hi[d] = 0; nbits[d] = 0;
            acc[d] = '0; prev_d[d] = 1'b0; fd_prev[d] = 1'b0; last_fd[d] = -100;
            if (d == 0) q0.delete(); else q1.delete();
            return;
        end
        if (fd_prev[d]) begin
            chk(rdy == 1'b1, $sformatf("ready_after_done%0d", d), int'(rdy), 1);
            chk(fdv == 1'b0, $sformatf("done_one_cycle%0d", d), int'(fdv), 0);
            fd_prev[d] = 1'b0;
        end
        if (dv && !prev_d[d]) begin
            if (nbits[d] == 0) begin
                if (qsz == 0) begin
                    chk(1'b0, $sformatf("rise_without_accept%0d", d), 1, 0);
                end else begin
                    e = (d == 0) ? q0[0] : q1[0];
                    chk(cyc - e.acc == 1, $sformatf("first_rise_latency%0d", d), cyc - e.acc, 1);
                end
                if (last_fd[d] == cyc - 3)
                    chk(lo_len[d] == BIT - prev_hi[d] + RST + 1, $sformatf("frame_gap%0d", d),
                        lo_len[d], BIT - prev_hi[d] + RST + 1);
            end else begin
                chk(prev_hi[d] + lo_len[d] == BIT, $sformatf("bit_period%0d", d),
                    prev_hi[d] + lo_len[d], BIT);
            end
            hi_len[d] = 1;
        end else if (dv) begin
            hi_len[d]++;
        end else if (prev_d[d]) begin
            if (hi_len[d] == T1H) acc[d] = {acc[d][70:0], 1'b1};
            else if (hi_len[d] == T0H) acc[d] = {acc[d][70:0], 1'b0};
            else chk(1'b0, $sformatf("high_width%0d", d), hi_len[d], T0H);
            nbits[d]++;
            prev_hi[d] = hi_len[d];
            lo_len[d] = 1;
        end else begin
            lo_len[d]++;
        end
        if (fdv) begin
            if (qsz == 0) begin
                chk(1'b0, $sformatf("unexpected_frame_done%0d", d), 1, 0);
            end else begin
                if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
                chk(nbits[d] == 24 * nl, $sformatf("bit_count%0d", d), nbits[d], 24 * nl);
                for (int i = 0; i < nl; i++)
                    chk(acc[d][24*i +: 24] == e.w, $sformatf("word%0d_led%0d", d, i),
                        int'(acc[d][24*i +: 24]), int'(e.w));
                chk(cyc - e.acc == 24 * nl * BIT + RST - 1, $sformatf("busy_time%0d", d),
                    cyc - e.acc + 1, 24 * nl * BIT + RST);
                chk(rdy == 1'b0 && dv == 1'b0, $sformatf("done_line_state%0d", d),
                    int'({rdy, dv}), 0);
            end
            nbits[d] = 0;
            acc[d] = '0;
            fd_prev[d] = 1'b1;
            last_fd[d] = cyc;
        end
        prev_d[d] = dv;
    endtask

    always @(negedge clk) begin
        mon_step(0, dout_w[0], fd_w[0], ready_w[0]);
        mon_step(1, dout_w[1], fd_w[1], ready_w[1]);
    end

    task automatic wait_ready(input int d, input logic lvl, input int limit);
        int n = 0;
        while (ready_w[d] !== lvl && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) chk(1'b0, $sformatf("timeout_ready%0d_%0d", d, lvl), n, limit);
    endtask

    task automatic send(input int d, input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
        @(negedge clk);
        wait_ready(d, 1'b1, 2000);
        green = g; red = r; blue = b;
        valid_w[d] = 1'b1;
        @(negedge clk);
        valid_w[d] = 1'b0;
    endtask

    task automatic wait_frame(input int d);
        wait_ready(d, 1'b0, 5);
        wait_ready(d, 1'b1, 2000);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        valid_w[0] = 1'b0;
        valid_w[1] = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                chk(dout_w[d] == 1'b0 && ready_w[d] == 1'b1 && fd_w[d] == 1'b0,
                    $sformatf("idle_outputs%0d", d),
                    int'({dout_w[d], ready_w[d], fd_w[d]}), 3'b010);
        end

        send(0, 8'h80, 8'h00, 8'h01);
        wait_frame(0);

        send(0, 8'hFF, 8'hFF, 8'hFF);
        repeat (30) @(negedge clk);
        green = 8'h00; red = 8'h00; blue = 8'h00;
        valid_w[0] = 1'b1;
        @(negedge clk);
        valid_w[0] = 1'b0;
        wait_ready(0, 1'b1, 2000);
        repeat (2) @(negedge clk);

        send(1, 8'hA5, 8'h3C, 8'h0F);
        wait_frame(1);

        for (int k = 0; k < 4; k++) begin
            send(0, 8'($urandom), 8'($urandom), 8'($urandom));
            wait_frame(0);
        end
        for (int k = 0; k < 2; k++) begin
            send(1, 8'($urandom), 8'($urandom), 8'($urandom));
            wait_frame(1);
        end

        // Abort in the middle of bit 10 while the line is high
        send(0, 8'($urandom), 8'($urandom), 8'($urandom));
        n = 0;
        while (!(nbits[0] == 10 && dout_w[0] == 1'b1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(n < 500, "reach_bit10", n, 500);
        #1 reset = 1'b0;
        #1;
        chk(dout_w[0] == 1'b0, "async_reset_dout", int'(dout_w[0]), 0);
        chk(ready_w[0] == 1'b1, "async_reset_ready", int'(ready_w[0]), 1);
        chk(fd_w[0] == 1'b0, "async_reset_done", int'(fd_w[0]), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        send(0, 8'($urandom), 8'($urandom), 8'($urandom));
        wait_frame(0);

        // valid held high: each accept carries whatever is on the inputs at that edge
        @(negedge clk);
        green = 8'($urandom); red = 8'($urandom); blue = 8'($urandom);
        valid_w[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ready(0, 1'b0, 5);
            green = 8'($urandom); red = 8'($urandom); blue = 8'($urandom);
            if (k == 3) valid_w[0] = 1'b0;
            wait_ready(0, 1'b1, 2000);
        end
        repeat (5) @(negedge clk);

        chk(q0.size() == 0, "pending_frames0", q0.size(), 0);
        chk(q1.size() == 0, "pending_frames1", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
